adc_ch_sched: RTL
=================

# adc_ch_sched

Round-robin channel scheduler for the EG4S20 ADC hard macro, sitting between the macro and the SPI slave inside `adc_top`. When enabled, it visits every channel selected by an 8-bit mask in turn. For each channel it drives the channel select, waits a settle interval, issues a one-cycle start pulse and waits for end-of-conversion. It stores each 12-bit result in a per-channel register bank with a "fresh" flag, which the SPI layer reads by channel index.

## Interface
- SETTLE_CYC, 4, cycles `ADC_CH` is held stable before `ADC_SOC` (1..255)
- TIMEOUT_CYC, 255, cycles spent in WAIT_EOC without `ADC_EOC` before abort (1..255)
- CLK_IN  in  1  24 MHz system clock, all logic on rising edge
- XRES_IN  in  1  asynchronous active-low reset
- EN  in  1  scan enable
- CH_MASK  in  8  channel enable mask, bit n = channel n
- ADC_CH  out  3  channel select to ADC macro
- ADC_SOC  out  1  start-of-conversion, one-cycle pulse
- ADC_EOC  in  1  end-of-conversion from macro, sampled only in WAIT_EOC
- ADC_DATA  in  12  conversion result, valid with `ADC_EOC`
- RD_CH  in  3  SPI read channel index
- RD_STB  in  1  one-cycle read strobe, clears fresh[`RD_CH`]
- RD_DATA  out  12  result[`RD_CH`], combinational
- FRESH  out  8  per-channel new-data flags
- CONV_DONE  out  1  one-cycle pulse when a result is stored
- ERR  out  1  sticky timeout flag
- ERR_CH  out  3  channel of the most recent timeout
- ERR_CLR  in  1  clears `ERR`
- BUSY  out  1  high in every state except IDLE

## Operation
- States: IDLE, SELECT, START, WAIT_EOC.
- **IDLE -> SELECT**
  - Taken on the edge where EN=1 and CH_MASK≠0.
  - On the same edge, ADC_CH loads the first channel: the lowest set bit strictly above the last visited channel, wrapping to the lowest set bit.
  - After reset, the last visited channel counts as 7, so the scan starts at the lowest set bit.
- **SELECT**
  - Stays for exactly SETTLE_CYC cycles (down-counter).
  - Then goes to START.
- **START**
  - ADC_SOC=1 for this single cycle.
  - Then goes to WAIT_EOC and clears the timeout counter.
- **WAIT_EOC with EOC**
  - On the edge with ADC_EOC=1: result[ADC_CH] <= ADC_DATA, fresh[ADC_CH] <= 1, and CONV_DONE=1 for the next cycle.
  - If EN=1 and CH_MASK≠0, go to SELECT with ADC_CH = next channel; otherwise go to IDLE.
- **WAIT_EOC timeout**
  - After TIMEOUT_CYC cycles with no EOC: ERR <= 1 and ERR_CH <= ADC_CH.
  - No store and no CONV_DONE.
  - Advance exactly as for a completed conversion.
- **Next-channel rule**
  - Computed from the CH_MASK value at the transition edge.
  - A single-bit mask revisits the same channel.
- **Mask changes mid-conversion:** the current conversion completes and stores even if its bit was cleared.
- **EN deasserted mid-scan:** the current conversion completes and stores, then the block goes to IDLE. ADC_CH holds its last value.
- **ADC_EOC outside WAIT_EOC:** ignored.
- **RD_STB:** clears fresh[RD_CH]. If it coincides with a store to the same channel, the set wins and fresh stays 1.
- **ERR_CLR:** clears ERR. If it coincides with a timeout, the set wins. ERR_CH is not cleared.
- **Reset values** (XRES_IN low, asynchronous, valid at any point mid-operation):
  - State IDLE.
  - ADC_CH=0, ADC_SOC=0, CONV_DONE=0, BUSY=0.
  - FRESH=0, ERR=0, ERR_CH=0.
  - All results 0, so RD_DATA=0.

## Timing
- Edge 0: IDLE sees EN. Cycles 1..SETTLE_CYC: SELECT. Cycle SETTLE_CYC+1: ADC_SOC high.
- With EOC arriving k cycles into WAIT_EOC (k≥1): the store edge ends cycle SETTLE_CYC+1+k, and FRESH/CONV_DONE are visible the following cycle.
- Per-channel period = SETTLE_CYC + 1 + k cycles. With default settle and k=1, that is 6 cycles (250 ns at 24 MHz).
- Timeout period = SETTLE_CYC + 1 + TIMEOUT_CYC cycles.
- RD_DATA is combinational from RD_CH and the result bank; a store is visible the cycle after the store edge.
- ADC_SOC is never high for two consecutive cycles and is never high outside START.

## Test plan
- **Single-channel scan:**
  - Stimulus: CH_MASK=8'h01, EN=1, EOC model replies k=3 with 12'hA5A.
  - Response: ADC_SOC pulses every 8 cycles on channel 0; result[0]=12'hA5A; FRESH=8'h01; CONV_DONE once per conversion.
- **Round-robin with wrap:**
  - Stimulus: CH_MASK=8'b1010_0100, EOC returns data = {9'h0, channel}.
  - Response: ADC_CH sequence 2,5,7,2,5,…; RD_DATA for RD_CH=5 reads 12'h005.
- **Timeout:**
  - Stimulus: EOC model silent on channel 3, CH_MASK=8'h0C.
  - Response: after 4+1+255 cycles ERR=1, ERR_CH=3, fresh[3]=0; scan continues to channel 2; ERR_CLR drops ERR.
- **Read/store collision:**
  - Stimulus: RD_STB with RD_CH=2 on the same edge as a store to channel 2.
  - Response: FRESH[2] stays 1. RD_STB on channel 2 with no store clears it to 0.
- **EN drop mid-conversion:**
  - Stimulus: EN=0 during WAIT_EOC on channel 4.
  - Response: EOC still stores result[4], then IDLE with BUSY=0; no further ADC_SOC.
- **Reset mid-operation:**
  - Stimulus: XRES_IN low during SELECT.
  - Response: immediately ADC_SOC=0, BUSY=0, FRESH=0, ADC_CH=0, RD_DATA=0. After release, the first channel visited is the lowest set mask bit.

Source files
------------

// File: rtl/adc_ch_sched.sv
// Round-robin channel scheduler for the EG4S20 ADC macro: selects each enabled
// channel, settles, starts a conversion and stores the result in a per-channel bank.
module adc_ch_sched #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        CLK_IN,
  input  logic        XRES_IN,
  input  logic        EN,
  input  logic [7:0]  CH_MASK,
  output logic [2:0]  ADC_CH,
  output logic        ADC_SOC,
  input  logic        ADC_EOC,
  input  logic [11:0] ADC_DATA,
  input  logic [2:0]  RD_CH,
  input  logic        RD_STB,
  output logic [11:0] RD_DATA,
  output logic [7:0]  FRESH,
  output logic        CONV_DONE,
  output logic        ERR,
  output logic [2:0]  ERR_CH,
  input  logic        ERR_CLR,
  output logic        BUSY
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    START    = 2'd2,
    WAIT_EOC = 2'd3
  } state_t;

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] TMO_LAST    = 8'(TIMEOUT_CYC - 1);

  state_t      state_r;
  logic [2:0]  ch_r;
  logic [2:0]  last_ch_r;
  logic [2:0]  err_ch_r;
  logic [7:0]  settle_r;
  logic [7:0]  tmo_r;
  logic [7:0]  fresh_r;
  logic        soc_r;
  logic        conv_done_r;
  logic        err_r;
  logic        busy_r;
  logic [11:0] result_r [0:7];

  logic        scan_ok_s;
  logic        tmo_hit_s;
  logic [2:0]  next_ch_s;

  // Circular search upward from the last channel; a lone bit finds itself at i=8.
  function automatic logic [2:0] next_ch_f(input logic [7:0] mask, input logic [2:0] last);
    logic [2:0] idx;
    logic       found;
    next_ch_f = last;
    found     = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = last + 3'(i);
      if (!found && mask[idx]) begin
        next_ch_f = idx;
        found     = 1'b1;
      end
    end
  endfunction

  assign scan_ok_s = EN && (CH_MASK != 8'h00);
  assign next_ch_s = next_ch_f(CH_MASK, last_ch_r);
  assign tmo_hit_s = (tmo_r == TMO_LAST);

  assign ADC_CH    = ch_r;
  assign ADC_SOC   = soc_r;
  assign FRESH     = fresh_r;
  assign CONV_DONE = conv_done_r;
  assign ERR       = err_r;
  assign ERR_CH    = err_ch_r;
  assign BUSY      = busy_r;
  assign RD_DATA   = result_r[RD_CH];

  // Scheduler FSM, result bank and status flags.
  always_ff @(posedge CLK_IN or negedge XRES_IN) begin
    if (!XRES_IN) begin
      state_r     <= IDLE;
      ch_r        <= 3'd0;
      last_ch_r   <= 3'd7;
      err_ch_r    <= 3'd0;
      settle_r    <= 8'd0;
      tmo_r       <= 8'd0;
      fresh_r     <= 8'h00;
      soc_r       <= 1'b0;
      conv_done_r <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        result_r[i] <= 12'h000;
      end
    end else begin
      soc_r       <= 1'b0;
      conv_done_r <= 1'b0;
      // Clears come first so a coincident store or timeout below overrides them.
      if (RD_STB) begin
        fresh_r[RD_CH] <= 1'b0;
      end
      if (ERR_CLR) begin
        err_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (scan_ok_s) begin
            state_r   <= SELECT;
            ch_r      <= next_ch_s;
            last_ch_r <= next_ch_s;
            settle_r  <= SETTLE_LOAD;
            busy_r    <= 1'b1;
          end else begin
            busy_r    <= 1'b0;
          end
        end
        SELECT: begin
          if (settle_r == 8'd0) begin
            state_r <= START;
            soc_r   <= 1'b1;
          end else begin
            settle_r <= settle_r - 8'd1;
          end
        end
        START: begin
          state_r <= WAIT_EOC;
          tmo_r   <= 8'd0;
        end
        WAIT_EOC: begin
          if (ADC_EOC || tmo_hit_s) begin
            if (ADC_EOC) begin
              result_r[ch_r] <= ADC_DATA;
              fresh_r[ch_r]  <= 1'b1;
              conv_done_r    <= 1'b1;
            end else begin
              err_r    <= 1'b1;
              err_ch_r <= ch_r;
            end
            if (scan_ok_s) begin
              state_r   <= SELECT;
              ch_r      <= next_ch_s;
              last_ch_r <= next_ch_s;
              settle_r  <= SETTLE_LOAD;
            end else begin
              state_r <= IDLE;
              busy_r  <= 1'b0;
            end
          end else begin
            tmo_r <= tmo_r + 8'd1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule
